// File: rtl/led_pwm_monitor.sv
// led_pwm_monitor: measures the duty (high clocks per window) of each PWM LED
// line and reports the brightest channel ("flow head") for self-test and debug.
module led_pwm_monitor #(
  parameter int NUM_CH      = 8,
  parameter int PWM_PERIOD  = 901,
  parameter int DUTY_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        pwm_in,
  output logic [NUM_CH*DUTY_W-1:0] duty_flat,
  output logic                     duty_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] head_idx,
  output logic                     head_valid,
  output logic                     head_change,
  output logic                     all_dark
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(PWM_PERIOD - 1);

  // First window after start-up or re-enable is thrown away because it is partial.
  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;
  logic [0:0]        state;
  logic [CNT_W-1:0]  win_cnt;
  logic [DUTY_W-1:0] hi_cnt [NUM_CH];
  logic [DUTY_W-1:0] duty   [NUM_CH];
  logic              prior_valid;
  logic [IDX_W-1:0]  best_idx;
  logic [DUTY_W-1:0] best_val;
  logic              dark_now;

  // Synchronizer chain for the possibly asynchronous PWM lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pwm_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Window counter, per-channel high counters, warm-up FSM and duty latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WARMUP;
      win_cnt    <= '0;
      duty_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        hi_cnt[i] <= '0;
        duty[i]   <= '0;
      end
    end else if (!en) begin
      state      <= ST_WARMUP;
      win_cnt    <= '0;
      duty_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hi_cnt[i] <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt <= '0;
      state   <= ST_RUN;
      for (int i = 0; i < NUM_CH; i++) hi_cnt[i] <= '0;
      if (state == ST_RUN) begin
        duty_valid <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) duty[i] <= hi_cnt[i] + DUTY_W'(s[i]);
      end else begin
        duty_valid <= 1'b0;
      end
    end else begin
      win_cnt    <= win_cnt + 1'b1;
      duty_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) hi_cnt[i] <= hi_cnt[i] + DUTY_W'(s[i]);
    end
  end

  // Flatten the latched duties onto the output bus.
  always_comb begin
    duty_flat = '0;
    for (int i = 0; i < NUM_CH; i++) duty_flat[i*DUTY_W +: DUTY_W] = duty[i];
  end

  // Argmax over latched duties; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = duty[0];
    dark_now = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (duty[i] != '0) dark_now = 1'b0;
      if (duty[i] > best_val) begin
        best_val = duty[i];
        best_idx = IDX_W'(i);
      end
    end
  end

  // Head register follows duty_valid by one clock; change only against a prior head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_idx    <= '0;
      head_valid  <= 1'b0;
      head_change <= 1'b0;
      all_dark    <= 1'b0;
      prior_valid <= 1'b0;
    end else if (!en) begin
      head_valid  <= 1'b0;
      head_change <= 1'b0;
      prior_valid <= 1'b0;
    end else if (duty_valid) begin
      head_idx    <= best_idx;
      head_valid  <= 1'b1;
      head_change <= prior_valid && (best_idx != head_idx);
      all_dark    <= dark_now;
      prior_valid <= 1'b1;
    end else begin
      head_valid  <= 1'b0;
      head_change <= 1'b0;
    end
  end

endmodule
